// File: rtl/membank_arbiter.sv
// membank_arbiter: shares one 256x16 memory bank between the control unit (CU)
//   and the program loader (LD). One access per cycle, grant in the request cycle,
//   read data returned one cycle after the grant with a registered valid tag.
// Ports: CLK100MHZ/rst (sync, active-high); cu_* and ld_* request/grant/read-return
//   groups; mem_* bank command pins; busy_ld diagnostic (last grant went to LD).
// Optional: define MBARB_STATS_EN to add saturating grant/conflict counters
//   (cu_cnt, ld_cnt, conflict_cnt).
module membank_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int ARB_MODE = 0   // 0 = round-robin, 1 = fixed priority (CU wins)
) (
  input  logic          CLK100MHZ,
  input  logic          rst,
  input  logic          cu_req,
  input  logic          cu_we,
  input  logic [AW-1:0] cu_addr,
  input  logic [DW-1:0] cu_wdata,
  output logic          cu_gnt,
  output logic          cu_rvalid,
  output logic [DW-1:0] cu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy_ld
`ifdef MBARB_STATS_EN
  ,
  output logic [15:0]   cu_cnt,
  output logic [15:0]   ld_cnt,
  output logic [15:0]   conflict_cnt
`endif
);

  // last_owner / rd_owner encoding: 1 = loader, 0 = CU
  logic          last_owner;
  logic          pend;
  logic          rd_owner;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          any_gnt;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Grant decision; both grants are held low while in reset.
  always_comb begin
    cu_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!rst) begin
      if (ARB_MODE == 1) begin
        cu_gnt = cu_req;
        ld_gnt = ld_req & ~cu_req;
      end else if (cu_req && ld_req) begin
        // tie: whoever was not served last wins
        cu_gnt = last_owner;
        ld_gnt = ~last_owner;
      end else begin
        cu_gnt = cu_req;
        ld_gnt = ld_req;
      end
    end
  end

  // Winner's command fields
  always_comb begin
    any_gnt   = cu_gnt | ld_gnt;
    win_we    = cu_gnt ? cu_we    : ld_we;
    win_addr  = cu_gnt ? cu_addr  : ld_addr;
    win_wdata = cu_gnt ? cu_wdata : ld_wdata;
  end

  // Memory command: live from the winner, otherwise hold the shadowed values
  always_comb begin
    mem_read  = any_gnt & ~win_we;
    mem_write = any_gnt &  win_we;
    mem_addr  = any_gnt ? win_addr  : addr_q;
    mem_wdata = any_gnt ? win_wdata : wdata_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      last_owner <= 1'b1;   // CU wins the first tie after reset
      busy_ld    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pend       <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (any_gnt) begin
        last_owner <= ld_gnt;
        busy_ld    <= ld_gnt;
        addr_q     <= win_addr;
        wdata_q    <= win_wdata;
      end
      // a new read may be issued while the previous one returns
      pend     <= any_gnt & ~win_we;
      rd_owner <= ld_gnt;
    end
  end

  // Read return: both ports see the bank data, only the owner's valid is raised
  always_comb begin
    cu_rvalid = pend & ~rd_owner & ~rst;
    ld_rvalid = pend &  rd_owner & ~rst;
    cu_rdata  = mem_rdata;
    ld_rdata  = mem_rdata;
  end

`ifdef MBARB_STATS_EN
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      cu_cnt       <= '0;
      ld_cnt       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (cu_gnt && (cu_cnt != 16'hFFFF))
        cu_cnt <= cu_cnt + 16'd1;
      if (ld_gnt && (ld_cnt != 16'hFFFF))
        ld_cnt <= ld_cnt + 16'd1;
      if (cu_req && ld_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_membank_arbiter.sv
module tb_membank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cu_req = 1'b0, cu_we = 1'b0;
  logic [7:0]  cu_addr = '0;
  logic [15:0] cu_wdata = '0;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_wdata = '0;
  logic [15:0] mem_rdata = '0;

  // round-robin instance outputs
  logic        cu_gnt, cu_rvalid, ld_gnt, ld_rvalid, mem_read, mem_write, busy_ld;
  logic [15:0] cu_rdata, ld_rdata, mem_wdata;
  logic [7:0]  mem_addr;
  // fixed-priority instance outputs
  logic        fp_cu_gnt, fp_cu_rvalid, fp_ld_gnt, fp_ld_rvalid, fp_mem_read, fp_mem_write, fp_busy_ld;
  logic [15:0] fp_cu_rdata, fp_ld_rdata, fp_mem_wdata;
  logic [7:0]  fp_mem_addr;
`ifdef MBARB_STATS_EN
  logic [15:0] cu_cnt, ld_cnt, conflict_cnt;
  logic [15:0] fp_cu_cnt, fp_ld_cnt, fp_conflict_cnt;
`endif

  always #5 clk = ~clk;

  membank_arbiter #(.AW(8), .DW(16), .ARB_MODE(0)) dut (
    .CLK100MHZ(clk), .rst(rst),
    .cu_req(cu_req), .cu_we(cu_we), .cu_addr(cu_addr), .cu_wdata(cu_wdata),
    .cu_gnt(cu_gnt), .cu_rvalid(cu_rvalid), .cu_rdata(cu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy_ld(busy_ld)
`ifdef MBARB_STATS_EN
    , .cu_cnt(cu_cnt), .ld_cnt(ld_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  membank_arbiter #(.AW(8), .DW(16), .ARB_MODE(1)) dut_fp (
    .CLK100MHZ(clk), .rst(rst),
    .cu_req(cu_req), .cu_we(cu_we), .cu_addr(cu_addr), .cu_wdata(cu_wdata),
    .cu_gnt(fp_cu_gnt), .cu_rvalid(fp_cu_rvalid), .cu_rdata(fp_cu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(fp_ld_gnt), .ld_rvalid(fp_ld_rvalid), .ld_rdata(fp_ld_rdata),
    .mem_addr(fp_mem_addr), .mem_read(fp_mem_read), .mem_write(fp_mem_write),
    .mem_wdata(fp_mem_wdata), .mem_rdata(mem_rdata), .busy_ld(fp_busy_ld)
`ifdef MBARB_STATS_EN
    , .cu_cnt(fp_cu_cnt), .ld_cnt(fp_ld_cnt), .conflict_cnt(fp_conflict_cnt)
`endif
  );

  // Memory bank model driven by the round-robin instance
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata     <= mem[mem_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic cr, input logic cw, input logic [7:0] ca,
                        input logic [15:0] cd, input logic lr, input logic lw,
                        input logic [7:0] la, input logic [15:0] ldd);
    rst = r; cu_req = cr; cu_we = cw; cu_addr = ca; cu_wdata = cd;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ldd;
  endtask

  typedef struct {
    logic        rst;
    logic        cr, cw;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic        lr, lw;
    logic [7:0]  la;
    logic [15:0] ldd;
    logic        cg, lg, mr, mw;
    logic        ck_ma;
    logic [7:0]  ma;
    logic        crv, lrv;
    logic [15:0] rd;
    logic        bl;
  } vec_t;

  function automatic vec_t mk(logic r, logic cr, logic cw, logic [7:0] ca, logic [15:0] cd,
                              logic lr, logic lw, logic [7:0] la, logic [15:0] ldd,
                              logic cg, logic lg, logic mr, logic mw, logic ck_ma,
                              logic [7:0] ma, logic crv, logic lrv, logic [15:0] rd, logic bl);
    vec_t v;
    v.rst = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.lr = lr; v.lw = lw; v.la = la; v.ldd = ldd;
    v.cg = cg; v.lg = lg; v.mr = mr; v.mw = mw; v.ck_ma = ck_ma; v.ma = ma;
    v.crv = crv; v.lrv = lrv; v.rd = rd; v.bl = bl;
    return v;
  endfunction

  vec_t vt[20];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;

    //            rst cr cw ca     cd       lr lw la     ldd       cg lg mr mw ck ma     crv lrv rd        bl
    vt[0]  = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 8'h00, 0, 0, 16'h0000, 0); // reset state
    vt[1]  = mk(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 1, 8'h10, 0, 0, 16'h0000, 0); // CU read 0x10
    vt[2]  = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 8'h10, 1, 0, 16'hBEEF, 0); // data back, addr held
    vt[3]  = mk(0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'h1234, 0, 1, 0, 1, 1, 8'h20, 0, 0, 16'h0000, 0); // LD write 0x20
    vt[4]  = mk(0, 1, 0, 8'h20, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 1, 8'h20, 0, 0, 16'h0000, 1); // CU read 0x20
    vt[5]  = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 8'h20, 1, 0, 16'h1234, 0); // new value seen
    vt[6]  = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 16'h0000, 0);
    vt[7]  = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 8'h00, 0, 0, 16'h0000, 0);
    vt[8]  = mk(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 1, 0, 1, 0, 1, 8'h10, 0, 0, 16'h0000, 0); // RR: CU
    vt[9]  = mk(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 0, 1, 1, 0, 1, 8'h20, 1, 0, 16'hBEEF, 0); // LD
    vt[10] = mk(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 1, 0, 1, 0, 1, 8'h10, 0, 1, 16'h1234, 1); // CU
    vt[11] = mk(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 0, 1, 1, 0, 1, 8'h20, 1, 0, 16'hBEEF, 0); // LD
    vt[12] = mk(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 1, 0, 1, 0, 1, 8'h10, 0, 1, 16'h1234, 1); // CU
    vt[13] = mk(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 0, 1, 1, 0, 1, 8'h20, 1, 0, 16'hBEEF, 0); // LD
    vt[14] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 8'h20, 0, 1, 16'h1234, 1);
    vt[15] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 8'h20, 0, 0, 16'h0000, 1);
    vt[16] = mk(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 0, 1, 8'h10, 0, 0, 16'h0000, 1); // CU read
    vt[17] = mk(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 16'h0000, 0); // rst mid-read
    vt[18] = mk(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000, 1, 0, 1, 0, 1, 8'h10, 0, 0, 16'h0000, 0); // tie -> CU
    vt[19] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 1, 8'h10, 1, 0, 16'hBEEF, 0);

    // initial reset
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      set_in(vt[i].rst, vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd,
             vt[i].lr, vt[i].lw, vt[i].la, vt[i].ldd);
      @(negedge clk);
      chk($sformatf("v%0d cu_gnt", i), {31'd0, cu_gnt}, {31'd0, vt[i].cg});
      chk($sformatf("v%0d ld_gnt", i), {31'd0, ld_gnt}, {31'd0, vt[i].lg});
      chk($sformatf("v%0d mem_read", i), {31'd0, mem_read}, {31'd0, vt[i].mr});
      chk($sformatf("v%0d mem_write", i), {31'd0, mem_write}, {31'd0, vt[i].mw});
      if (vt[i].ck_ma)
        chk($sformatf("v%0d mem_addr", i), {24'd0, mem_addr}, {24'd0, vt[i].ma});
      if (vt[i].mw)
        chk($sformatf("v%0d mem_wdata", i), {16'd0, mem_wdata},
            {16'd0, (vt[i].cg ? vt[i].cd : vt[i].ldd)});
      chk($sformatf("v%0d cu_rvalid", i), {31'd0, cu_rvalid}, {31'd0, vt[i].crv});
      chk($sformatf("v%0d ld_rvalid", i), {31'd0, ld_rvalid}, {31'd0, vt[i].lrv});
      if (vt[i].crv)
        chk($sformatf("v%0d cu_rdata", i), {16'd0, cu_rdata}, {16'd0, vt[i].rd});
      if (vt[i].lrv)
        chk($sformatf("v%0d ld_rdata", i), {16'd0, ld_rdata}, {16'd0, vt[i].rd});
      chk($sformatf("v%0d busy_ld", i), {31'd0, busy_ld}, {31'd0, vt[i].bl});
    end

    // Fixed priority: both request 4 cycles, then CU drops
    @(posedge clk); #1;
    set_in(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      set_in(0, (c < 4), 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
      @(negedge clk);
      chk($sformatf("fp c%0d cu_gnt", c), {31'd0, fp_cu_gnt}, {31'd0, (c < 4)});
      chk($sformatf("fp c%0d ld_gnt", c), {31'd0, fp_ld_gnt}, {31'd0, (c >= 4)});
    end

`ifdef MBARB_STATS_EN
    // both, both, cu, cu, ld -> CU 3, LD 2, conflicts 2
    @(posedge clk); #1;
    set_in(1, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    @(posedge clk); #1; set_in(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
    @(posedge clk); #1; set_in(0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
    @(posedge clk); #1; set_in(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h20, 16'h0000);
    @(posedge clk); #1; set_in(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h20, 16'h0000);
    @(posedge clk); #1; set_in(0, 0, 0, 8'h10, 16'h0000, 1, 0, 8'h20, 16'h0000);
    @(posedge clk); #1; set_in(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    @(negedge clk);
    chk("stats cu_cnt", {16'd0, cu_cnt}, 32'd3);
    chk("stats ld_cnt", {16'd0, ld_cnt}, 32'd2);
    chk("stats conflict_cnt", {16'd0, conflict_cnt}, 32'd2);
    @(posedge clk); #1; set_in(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
    repeat (70000) @(posedge clk);
    #1; set_in(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    @(negedge clk);
    chk("stats cu_cnt saturated", {16'd0, cu_cnt}, 32'h0000FFFF);
    chk("stats ld_cnt held", {16'd0, ld_cnt}, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
